// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF reader.
// Challenge layout is {idx_a, idx_b}, with idx_b in the low field.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COUNT   = 2'd2,
    ST_COMPARE = 2'd3
  } state_e;

  localparam int N_RO_DEF   = 16;
  localparam int IDX_W_DEF  = 4;
  localparam int CHAL_B_LSB = 0;

  function automatic int chal_a_lsb(input int idx_w);
    return idx_w;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one raw oscillator output, detects rising edges and
// accumulates them in a saturating counter while cnt_en is high.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             ro_in,
  output logic [CNT_W-1:0] count
);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync0_d = ro_in;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
    rise    = sync1_q & ~prev_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ro_puf_reader.sv
// RO PUF measurement front-end: enables a challenged oscillator pair, counts
// both over a fixed window and reports which one ran faster.
//
// state      | meaning
// IDLE       | waiting for start; results held
// SETTLE     | pair enabled, counters held at 0
// COUNT      | pair enabled, synchronised edges counted
// COMPARE    | pair disabled, results registered, done pulsed
module ro_puf_reader
  import ro_puf_pkg::*;
#(
  parameter int N_RO       = N_RO_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW     = 1024,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*IDX_W-1:0] challenge,
  output logic [N_RO-1:0]    ro_en,
  input  logic [N_RO-1:0]    ro_out,
  output logic               busy,
  output logic               done,
  output logic               response,
  output logic               tie,
  output logic               err,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b
);

  localparam int A_LSB   = chal_a_lsb(IDX_W);
  localparam int TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  function automatic logic [N_RO-1:0] pair_mask(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [N_RO-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    return m;
  endfunction

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [2*IDX_W-1:0] chal_q, chal_d;
  logic [N_RO-1:0]    ro_en_q, ro_en_d;
  logic               done_q, done_d;
  logic               resp_q, resp_d;
  logic               tie_q, tie_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;

  logic [IDX_W-1:0]   in_a, in_b, idx_a, idx_b;
  logic [CNT_W-1:0]   live_a, live_b;
  logic               clr, cnt_en;

  assign in_a   = challenge[A_LSB +: IDX_W];
  assign in_b   = challenge[CHAL_B_LSB +: IDX_W];
  assign idx_a  = chal_q[A_LSB +: IDX_W];
  assign idx_b  = chal_q[CHAL_B_LSB +: IDX_W];
  assign cnt_en = (state_q == ST_COUNT);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .cnt_en (cnt_en),
    .ro_in  (ro_out[idx_a]),
    .count  (live_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .cnt_en (cnt_en),
    .ro_in  (ro_out[idx_b]),
    .count  (live_b)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    chal_d  = chal_q;
    ro_en_d = ro_en_q;
    done_d  = 1'b0;
    resp_d  = resp_q;
    tie_d   = tie_q;
    err_d   = err_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d = challenge;
          clr    = 1'b1;
          if (in_a == in_b) begin
            state_d = ST_COMPARE;
          end else begin
            state_d = ST_SETTLE;
            timer_d = TMR_W'(SETTLE_CYC - 1);
            ro_en_d = pair_mask(in_a, in_b);
          end
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          state_d = ST_COUNT;
          timer_d = TMR_W'(WINDOW - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_COUNT: begin
        if (timer_q == '0) begin
          state_d = ST_COMPARE;
          ro_en_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        state_d = ST_IDLE;
        ro_en_d = '0;
        done_d  = 1'b1;
        // A degenerate challenge reports zero counts regardless of counter state.
        if (idx_a == idx_b) begin
          err_d   = 1'b1;
          resp_d  = 1'b0;
          tie_d   = 1'b0;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end else begin
          err_d   = 1'b0;
          resp_d  = (live_a > live_b);
          tie_d   = (live_a == live_b);
          cnt_a_d = live_a;
          cnt_b_d = live_b;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      chal_q  <= '0;
      ro_en_q <= '0;
      done_q  <= 1'b0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chal_q  <= chal_d;
      ro_en_q <= ro_en_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign response = resp_q;
  assign tie      = tie_q;
  assign err      = err_q;
  assign count_a  = cnt_a_q;
  assign count_b  = cnt_b_q;

endmodule

// File: doc/ro_puf_reader.md
# ro_puf_reader

Measurement front-end for the ring-oscillator PUF array. It accepts a challenge that selects two of the N_RO ring oscillators and enables only that pair. It counts rising edges of each selected oscillator over a fixed window of `clk` cycles and emits one response bit: whether oscillator A ran faster than oscillator B. It sits between the ring-oscillator bank, which it drives through `ro_en` and samples through `ro_out`, and the challenge/response controller, which drives `start` and consumes `done`.

## Interface
Parameters:
- `N_RO`, default 16: number of ring oscillators; must be a power of two.
- `IDX_W`, default 4: index width, equal to log2(N_RO).
- `SETTLE_CYC`, default 16: cycles the selected pair is enabled before counting starts.
- `WINDOW`, default 1024: counting window, in `clk` cycles.
- `CNT_W`, default 16: edge-counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `challenge`  in  2*IDX_W  {idx_a, idx_b}; idx_a is in the upper bits.
- `ro_en`  out  N_RO  one-hot-pair enable to the ring-oscillator bank.
- `ro_out`  in  N_RO  raw oscillator outputs; asynchronous to `clk`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- `response`  out  1  1 when count_a > count_b, otherwise 0.
- `tie`  out  1  1 when count_a == count_b.
- `err`  out  1  1 when idx_a == idx_b.
- `count_a`, `count_b`  out  CNT_W each  final edge counts of the last measurement.

## Operation
Reset values:
- `ro_en`, `busy`, `done`, `response`, `tie`, `err`, `count_a` and `count_b` are all 0.
- The state is IDLE.

Idle and start:
- IDLE with `start`=1: latch `challenge`, then branch.
  - If idx_a == idx_b, go to COMPARE directly with `err`=1 and both counts 0.
  - Otherwise clear both counters and go to SETTLE.
- `start` while `busy` is ignored and is not queued. The challenge is latched only on acceptance.

Settling and counting:
- SETTLE: `ro_en` has exactly bits idx_a and idx_b set. Hold for SETTLE_CYC cycles, with counters held at 0.
- COUNT: `ro_en` is unchanged. Run for exactly WINDOW cycles.
  - Each selected `ro_out` bit passes through a 2-flop synchronizer and then a rising-edge detector.
  - Each detected edge adds 1 to its counter.
  - Counters saturate at 2^CNT_W−1 and never wrap.
- Only edges detected in COUNT cycles are counted. This includes synchronizer-delayed edges from SETTLE that emerge during COUNT.

Compare and return to idle:
- COMPARE, one cycle:
  - `ro_en` goes to 0.
  - Register `count_a`, `count_b`, `response` and `tie`, and the `err` result of this measurement.
  - Pulse `done`.
  - Go to IDLE.
- On a tie, `response` is 0 and `tie` is 1. On error, `response` and `tie` are 0.
- Result outputs hold their values until the next `done`.

Reset and frequency limit:
- `rst_n` asserted in any state: immediately return to IDLE, drop `ro_en` to 0, clear all outputs, and discard the measurement.
- Input frequency limit: each `ro_out` must stay below clk/4 so that the synchronizer samples every edge. The divided oscillator outputs meet this limit.

## Timing
- Counted from the edge k that accepts `start`:
  - SETTLE occupies cycles k+1 .. k+SETTLE_CYC.
  - COUNT occupies the next WINDOW cycles.
  - COMPARE is the following cycle.
  - `done` is high for the single cycle after edge k+SETTLE_CYC+WINDOW+1.
- The error path is faster: `done` is high for the single cycle after edge k+1.
- `busy` rises the cycle after acceptance and falls together with `done`.
- A new `start` is accepted in the cycle after `done` at the earliest.
- Synchronizer latency is 2 cycles. Edge-to-count latency is 3 cycles.

## Structure
- The package `ro_puf_pkg` holds:
  - the state enum: IDLE, SETTLE, COUNT, COMPARE;
  - N_RO and IDX_W defaults;
  - the challenge field slicing constants.
- The sub-module `ro_edge_counter`, instantiated twice (A and B), contains:
  - the 2-flop synchronizer, edge detector and saturating CNT_W counter;
  - ports `clk`, `rst_n`, `clr`, `cnt_en`, `ro_in` and `count`.
- The top level holds the FSM, the challenge register, the `ro_en` decode, the `ro_out` mux and the compare logic.

## Test plan
- **Basic compare.** Behavioural RO 3 at period 20 clk and RO 7 at period 24 clk; SETTLE_CYC=16, WINDOW=1024; challenge 8'h37. Required: `ro_en`=16'h0088 during busy; `count_a`≈51, `count_b`≈42 (±1); `response`=1, `tie`=0; `done` at cycle k+1042.
- **Swapped challenge.** Same oscillators, challenge 8'h73. Required: `response`=0 and the counts swapped.
- **Error path.** Challenge 8'h55. Required: `err`=1, `response`=0, counts 0; `done` one cycle after acceptance; `ro_en` never nonzero.
- **Tie and saturation.** Two oscillators of identical period. Required: `tie`=1, `response`=0. Then CNT_W=4 with a fast RO. Required: the count holds at 15.
- **Start while busy.** Pulse `start` with a new challenge mid-COUNT. Required: it is ignored, and the result and latched challenge match the original request.
- **Reset mid-COUNT.** Assert `rst_n` low. Required: `ro_en`, `busy` and all outputs are 0 in the same cycle with no `done`. After release, a fresh measurement completes normally.
